// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, constants and fetch-stage types for the RV32I core
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small instruction buffer holding {pc, instr} pairs with flush
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    input  logic                     flush,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    fetch_entry_t mem_q [DEPTH];
    fetch_entry_t mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic pop_ok, push_ok;
    assign empty = count_q == '0;
    assign full  = count_q == CW'(DEPTH);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];
    // next pointers/occupancy; flush discards everything, pop frees room for a same-cycle push
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end
    // buffer state registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetch PC, single-outstanding imem requests, buffered valid/ready delivery
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic            CLK,
    input  logic            RST,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] fetch_pc
);
    localparam int CW = $clog2(DEPTH) + 1;
    fetch_state_e state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
    logic push, pop, issue, fifo_empty, fifo_full;
    logic [CW-1:0] count, entries_after;
    fetch_entry_t push_entry, head;
    logic unused_ok;
    assign unused_ok   = &{1'b0, redirect_pc[1:0], fifo_full};
    assign instr_valid = ~fifo_empty;
    assign instr       = instr_valid ? head.instr : NOP_INSTR;
    assign instr_pc    = instr_valid ? head.pc : '0;
    assign fetch_pc    = fetch_pc_q;
    assign imem_req    = issue;
    assign imem_addr   = fetch_pc_q;
    // request issue, PC update and FSM next state; redirect overrides everything
    always_comb begin
        pop           = instr_valid & instr_ready & ~redirect_valid;
        push          = (state_q == WAIT) & imem_rvalid & ~redirect_valid;
        push_entry    = '{pc: req_pc_q, instr: imem_rdata};
        entries_after = count - CW'(pop) + CW'(push);
        issue         = RST & ~redirect_valid & (entries_after < CW'(DEPTH)) &
                        ((state_q == IDLE) | ((state_q == WAIT) & imem_rvalid));
        fetch_pc_d    = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00} :
                        issue ? fetch_pc_q + 32'd4 : fetch_pc_q;
        req_pc_d      = issue ? fetch_pc_q : req_pc_q;
        state_d       = state_q;
        case (state_q)
            IDLE:    state_d = issue ? WAIT : IDLE;
            WAIT:    state_d = imem_rvalid ? (issue ? WAIT : IDLE) : (redirect_valid ? DROP : WAIT);
            DROP:    state_d = imem_rvalid ? IDLE : DROP;
            default: state_d = IDLE;
        endcase
    end
    // FSM and PC registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end
    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench with a fixed-latency in-order memory model
module tb_fetch_unit;
    import riscv_pkg::*;
    logic CLK = 1'b0;
    logic RST;
    logic imem_req, imem_rvalid, redirect_valid, instr_valid, instr_ready;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, instr, instr_pc, fetch_pc;
    int errors = 0, checks = 0, cyc = 0, lat = 1, req_count = 0, rc0;
    logic [31:0] exp_next = 32'h0;
    logic [31:0] exp_pc_q [$];
    logic [31:0] mem_addr_q [$];
    int mem_due_q [$];

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .CLK(CLK), .RST(RST), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .fetch_pc(fetch_pc)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // memory: returns each request's word lat cycles later, in order
    always @(negedge CLK) begin
        if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_addr_q.pop_front());
            void'(mem_due_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    end

    // monitor: checks request addresses and popped instructions against the scoreboard
    always @(negedge CLK) begin : mon
        logic [31:0] p;
        #2;
        if (imem_req) begin
            req_count++;
            check("req_addr", imem_addr, exp_next);
            exp_pc_q.push_back(exp_next);
            exp_next = exp_next + 32'd4;
            mem_addr_q.push_back(imem_addr);
            mem_due_q.push_back(cyc + lat);
        end
        if (instr_valid && instr_ready && !redirect_valid) begin
            if (exp_pc_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got instr_pc %h expected no instruction (cycle %0d)", instr_pc, cyc);
            end else begin
                p = exp_pc_q.pop_front();
                check("pop_pc", instr_pc, p);
                check("pop_instr", instr, mem_word(p));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic nxt;
        @(negedge CLK);
        redirect_valid = 1'b0;
        #3;
    endtask

    task automatic do_reset;
        @(negedge CLK);
        RST = 1'b0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        exp_pc_q.delete();
        exp_next = 32'h0;
        tick(2);
    endtask

    task automatic release_rst(input logic rdy);
        @(negedge CLK);
        RST = 1'b1;
        instr_ready = rdy;
        #3;
    endtask

    task automatic redir(input logic [31:0] t);
        @(negedge CLK);
        redirect_valid = 1'b1;
        redirect_pc = t;
        exp_pc_q.delete();
        exp_next = {t[31:2], 2'b00};
        #3;
        check("redir_no_req", 32'(imem_req), 0);
    endtask

    initial begin
        RST = 1'b0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        imem_rvalid = 1'b0;
        imem_rdata = 32'h0;
        tick(2);
        #3;
        check("rst_req", 32'(imem_req), 0);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_instr", instr, NOP_INSTR);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_fetch_pc", fetch_pc, 0);
        // streaming with 1-cycle memory
        release_rst(1'b1);
        check("t1_req0", 32'(imem_req), 1);
        check("t1_addr0", imem_addr, 32'h0);
        check("t1_valid0", 32'(instr_valid), 0);
        check("t1_nop0", instr, NOP_INSTR);
        nxt;
        check("t1_addr1", imem_addr, 32'h4);
        check("t1_valid1", 32'(instr_valid), 0);
        check("t1_nop1", instr, NOP_INSTR);
        nxt;
        check("t1_addr2", imem_addr, 32'h8);
        check("t1_valid2", 32'(instr_valid), 1);
        check("t1_pc2", instr_pc, 32'h0);
        nxt;
        check("t1_pc3", instr_pc, 32'h4);
        repeat (5) nxt;
        @(negedge CLK);
        instr_ready = 1'b0;
        repeat (6) nxt;
        check("t1_stall_req", 32'(imem_req), 0);
        check("t1_buffered", 32'(exp_pc_q.size()), 2);
        // consumer stalled from the start
        do_reset;
        rc0 = req_count;
        release_rst(1'b0);
        check("t2_addr0", imem_addr, 32'h0);
        repeat (5) nxt;
        check("t2_req_total", 32'(req_count - rc0), 2);
        check("t2_req_idle", 32'(imem_req), 0);
        check("t2_head", instr_pc, 32'h0);
        @(negedge CLK);
        instr_ready = 1'b1;
        #3;
        check("t2_resume_req", 32'(imem_req), 1);
        check("t2_resume_addr", imem_addr, 32'h8);
        nxt;
        @(negedge CLK);
        instr_ready = 1'b0;
        repeat (6) nxt;
        // redirect while a 3-cycle response is outstanding
        do_reset;
        lat = 3;
        release_rst(1'b1);
        repeat (3) nxt;
        redir(32'h100);
        nxt;
        check("t3_drop_req", 32'(imem_req), 0);
        check("t3_flushed", 32'(instr_valid), 0);
        nxt;
        check("t3_drop_rsp_req", 32'(imem_req), 0);
        nxt;
        check("t3_req", 32'(imem_req), 1);
        check("t3_addr", imem_addr, 32'h100);
        repeat (4) nxt;
        check("t3_valid", 32'(instr_valid), 1);
        check("t3_pc", instr_pc, 32'h100);
        @(negedge CLK);
        instr_ready = 1'b0;
        repeat (12) nxt;
        // redirect with same-cycle response and pop, then misaligned target and wrap
        do_reset;
        lat = 1;
        release_rst(1'b1);
        repeat (2) nxt;
        redir(32'h200);
        check("t4_pre_valid", 32'(instr_valid), 1);
        nxt;
        check("t4_flushed", 32'(instr_valid), 0);
        check("t4_req", 32'(imem_req), 1);
        check("t4_addr", imem_addr, 32'h200);
        redir(32'h103);
        nxt;
        check("t5_addr", imem_addr, 32'h100);
        check("t5_fetch_pc", fetch_pc, 32'h100);
        nxt;
        nxt;
        check("t5_valid", 32'(instr_valid), 1);
        check("t5_pc", instr_pc, 32'h100);
        check("t5_instr", instr, mem_word(32'h100));
        redir(32'hFFFF_FFFC);
        nxt;
        check("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
        nxt;
        check("t5_addr_wrap", imem_addr, 32'h0);
        check("t5_fetch_wrap", fetch_pc, 32'h0);
        nxt;
        check("t5_pc_top", instr_pc, 32'hFFFF_FFFC);
        nxt;
        check("t5_pc_wrap", instr_pc, 32'h0);
        @(negedge CLK);
        instr_ready = 1'b0;
        repeat (6) nxt;
        // reset in WAIT with one buffered entry; the stale response must be ignored
        do_reset;
        lat = 3;
        release_rst(1'b0);
        repeat (3) nxt;
        check("t6_addr1", imem_addr, 32'h4);
        @(negedge CLK);
        check("t6_pre_valid", 32'(instr_valid), 1);
        RST = 1'b0;
        exp_pc_q.delete();
        exp_next = 32'h0;
        #3;
        check("t6_rst_valid", 32'(instr_valid), 0);
        check("t6_rst_req", 32'(imem_req), 0);
        check("t6_rst_instr", instr, NOP_INSTR);
        check("t6_rst_fetch_pc", fetch_pc, 32'h0);
        nxt;
        @(negedge CLK);
        RST = 1'b1;
        #3;
        check("t6_req", 32'(imem_req), 1);
        check("t6_addr", imem_addr, 32'h0);
        nxt;
        check("t6_stale_ignored", 32'(instr_valid), 0);
        check("t6_fetch_pc", fetch_pc, 32'h4);
        @(negedge CLK);
        instr_ready = 1'b1;
        #3;
        nxt;
        nxt;
        check("t6_valid", 32'(instr_valid), 1);
        check("t6_pc", instr_pc, 32'h0);
        check("t6_instr", instr, mem_word(32'h0));
        @(negedge CLK);
        instr_ready = 1'b0;
        repeat (8) nxt;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch front end for the RV32I core. It holds the fetch PC and issues word requests to instruction memory. Returned instructions are buffered with their PCs in a small FIFO, and the decode/execute datapath consumes them over a valid/ready handshake. Branch/jump redirects from the ALU stage flush the buffer and discard any in-flight response.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset.
DEPTH, 2, instruction buffer entries (power of 2, ≥2).

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  reset, asynchronous, active-low.
imem_req  out  1  one-cycle request strobe; memory always accepts.
imem_addr  out  32  word-aligned fetch address, valid when imem_req=1.
imem_rvalid  in  1  response strobe, ≥1 cycle after request, in order.
imem_rdata  in  32  instruction word, valid with imem_rvalid.
redirect_valid  in  1  taken branch/jump this cycle.
redirect_pc  in  32  target address; bits [1:0] are ignored (forced 0).
instr_valid  out  1  buffer head valid.
instr_ready  in  1  consumer accepts head this cycle.
instr  out  32  head instruction; 32'h0000_0013 (NOP) when instr_valid=0.
instr_pc  out  32  PC of head instruction.
fetch_pc  out  32  current fetch pointer (debug/nextpc view).

Behaviour:
- Reset (RST=0, async): fetch_pc=RESET_PC, state IDLE, FIFO empty, imem_req=0, instr_valid=0, instr=NOP, instr_pc=0.
- States:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding; its response will be kept.
  - DROP: one request outstanding; its response will be discarded.
- Issue condition: imem_req=1 when (IDLE, or WAIT with imem_rvalid=1) and entries_after_this_cycle < DEPTH and redirect_valid=0. imem_addr=fetch_pc. The request is combinational from registered state.
- On issue: fetch_pc += 4 (wraps modulo 2^32); go to WAIT.
- WAIT + imem_rvalid: write {pc_of_request, imem_rdata} into the FIFO. Go to WAIT if a new request was issued this cycle, else IDLE.
- DROP + imem_rvalid: discard the data; go to IDLE. No issue happens this cycle.
- Throughput: with 1-cycle memory latency and instr_ready held high, one instruction per cycle.
- FIFO:
  - instr_valid is registered; the earliest it rises is the cycle after imem_rvalid. There is no bypass.
  - A pop occurs on instr_valid & instr_ready.
  - Simultaneous push and pop when full is legal, because occupancy is computed after the pop.
- Redirect (highest priority):
  - FIFO is flushed; instr_valid=0 next cycle.
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - No request is issued in the redirect cycle.
  - WAIT→DROP unless imem_rvalid is set the same cycle, in which case that response is dropped and the state goes to IDLE.
  - DROP stays DROP.
  - A redirect at cycle t yields imem_req at t+1 if the FIFO was IDLE or the response arrived at t.
  - Redirect with a simultaneous pop: the flush wins.
  - A redirect while DROP overwrites fetch_pc again.
- imem_rvalid in IDLE is ignored; this covers stale responses after reset.
- Reset asserted mid-operation clears everything immediately. Outstanding responses are ignored by the IDLE rule.

Decomposition:
- Shared package riscv_pkg:
  - XLEN=32
  - NOP_INSTR=32'h0000_0013
  - fetch state encoding (IDLE=2'd0, WAIT=2'd1, DROP=2'd2)
- One sub-module, fetch_fifo:
  - DEPTH entries of {pc[31:0], instr[31:0]}
  - push/pop/flush inputs; count, empty, full outputs
  - async active-low reset
- The FSM and PC logic stay in fetch_unit.

Test Plan:
1. Reset then release, 1-cycle memory, instr_ready=1 -> imem_addr 0x0,0x4,0x8 on consecutive cycles; instr_pc 0x0,0x4,0x8 one instruction per cycle starting 2 cycles after the first req; instr=NOP before that.
2. instr_ready=0 from start -> exactly 2 requests (0x0,0x4), imem_req stays 0; raise ready -> pops 0x0,0x4, next req addr 0x8.
3. Memory latency 3, redirect_pc=0x100 one cycle after req to 0x4 -> rdata for 0x4 discarded; next req 0x100 on the cycle after its rvalid; first instr_pc after flush = 0x100.
4. Redirect 0x200 in the same cycle as rvalid and a pop, FIFO holding 1 entry -> instr_valid=0 next cycle, req 0x200 next cycle.
5. Redirect to 0x103 -> imem_addr 0x100, instr_pc 0x100; fetch from 0xFFFF_FFFC -> next addr 0x0000_0000.
6. Pull RST low while in WAIT with 1 entry buffered -> instr_valid=0, imem_req=0 immediately; late rvalid after release ignored; first req addr RESET_PC.
